// File: rtl/example_text_memory_bus_ws_if.sv
// Fetch request/response bus plus synchronous text-memory port.
// slave: the fetch unit side (example_text_memory_bus_ws); master: requester + memory.
interface example_text_memory_bus_ws_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_AW     = 12
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_address;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_fault;
    logic                  mem_read;
    logic [MEM_AW-1:0]     mem_address;
    logic [DATA_WIDTH-1:0] mem_q;

    modport slave (
        input  req_valid, req_address, rsp_ready, mem_q,
        output req_ready, rsp_valid, rsp_data, rsp_fault,
        output mem_read, mem_address
    );

    modport master (
        output req_valid, req_address, rsp_ready, mem_q,
        input  req_ready, rsp_valid, rsp_data, rsp_fault,
        input  mem_read, mem_address
    );
endinterface

// File: rtl/example_text_memory_bus_ws.sv
// Text-region fetch bus: one outstanding word read with WAIT_STATES extra cycles.
// Ports: clock, reset (async, active-high), bus (slave modport: req/rsp handshakes, mem port).
// Optional: `define TEXT_BUS_FAULT_EN to answer out-of-range/misaligned fetches with rsp_fault.
module example_text_memory_bus_ws #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] TEXT_BASE   = 'h0040_0000,
    parameter int                    TEXT_WORDS  = 4096,
    parameter int                    WAIT_STATES = 0
) (
    input logic                         clock,
    input logic                         reset,
    example_text_memory_bus_ws_if.slave bus
);
    localparam int AW = $clog2(TEXT_WORDS);

    // One extra top bit so the upper bound never wraps.
    localparam logic [ADDR_WIDTH:0] LAST =
        {1'b0, TEXT_BASE} + (ADDR_WIDTH+1)'(4 * TEXT_WORDS) - 1'b1;

    typedef enum logic [1:0] {IDLE, WAIT, ISSUE, RESP} state_t;

    state_t                state;
    state_t                nxt;
    logic [3:0]            cnt;
    logic [AW-1:0]         idx;
    logic                  hit;
    logic                  pend;
    logic                  rdy_en;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  rd;

    logic                  accept;
    logic                  in_range;
    logic                  bad;
    logic [ADDR_WIDTH-1:0] off;
    logic [AW-1:0]         idx_w;

    assign in_range = ({1'b0, bus.req_address} >= {1'b0, TEXT_BASE})
                   && ({1'b0, bus.req_address} <= LAST);
    assign off      = bus.req_address - TEXT_BASE;
    assign idx_w    = AW'(off >> 2);

`ifdef TEXT_BUS_FAULT_EN
    logic fault_q;
    assign bad           = !in_range || (bus.req_address[1:0] != 2'b00);
    assign bus.rsp_fault = fault_q;
`else
    assign bad           = 1'b0;
    assign bus.rsp_fault = 1'b0;
`endif

    // rdy_en keeps req_ready low until the first edge after reset.
    assign bus.req_ready   = (state == IDLE) && rdy_en;
    assign accept          = bus.req_ready && bus.req_valid;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.mem_read    = rd;
    assign bus.mem_address = idx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        rd  = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (bad) begin
                        nxt = RESP;
                    end else if (WAIT_STATES == 0) begin
                        nxt = ISSUE;
                    end else begin
                        nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt <= 4'd1) begin
                    nxt = ISSUE;
                end
            end
            ISSUE: begin
                // Out-of-range fetches keep the timing but never touch memory.
                rd  = hit;
                nxt = RESP;
            end
            RESP: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // RESP is entered one cycle before mem_q is valid; pend marks that
    // capture cycle, during which rsp_valid is still low.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            idx         <= '0;
            hit         <= 1'b0;
            pend        <= 1'b0;
            rdy_en      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
`ifdef TEXT_BUS_FAULT_EN
            fault_q     <= 1'b0;
`endif
        end else begin
            rdy_en <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        idx <= idx_w;
                        hit <= in_range;
                        cnt <= 4'(WAIT_STATES);
`ifdef TEXT_BUS_FAULT_EN
                        fault_q <= bad;
`endif
                        if (bad) begin
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= '0;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                end
                ISSUE: begin
                    pend <= 1'b1;
                end
                RESP: begin
                    if (pend) begin
                        pend        <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= hit ? bus.mem_q : '0;
                    end else if (rsp_valid_q && bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/example_text_memory_bus_ws.md
EXAMPLE_TEXT_MEMORY_BUS_WS -- requirements
Module: example_text_memory_bus_ws

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: width of the response data and memory word in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32: width of the byte address.
REQ-003 The block SHALL have parameter TEXT_BASE, default 32'h00400000: first valid byte address.
REQ-004 The block SHALL have parameter TEXT_WORDS, default 4096: region size in words, power of two, at least 2.
REQ-005 The block SHALL have parameter WAIT_STATES, default 0: extra cycles inserted before each memory read, range 0..15.
REQ-006 The block SHALL have port clock, input, 1 bit: single clock, rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-008 The block SHALL have port req_valid, input, 1 bit: fetch request present.
REQ-009 The block SHALL have port req_ready, output, 1 bit: block can accept a request.
REQ-010 The block SHALL have port req_address, input, ADDR_WIDTH bits: byte address of the fetch.
REQ-011 The block SHALL have port rsp_valid, output, 1 bit: response present.
REQ-012 The block SHALL have port rsp_ready, input, 1 bit: consumer accepts the response.
REQ-013 The block SHALL have port rsp_data, output, DATA_WIDTH bits: fetched word.
REQ-014 The block SHALL have port rsp_fault, output, 1 bit: access error.
REQ-015 The block SHALL have port mem_read, output, 1 bit: memory read strobe.
REQ-016 The block SHALL have port mem_address, output, $clog2(TEXT_WORDS) bits: word index.
REQ-017 The block SHALL have port mem_q, input, DATA_WIDTH bits: synchronous memory output, valid one cycle after mem_read.

Function
REQ-018 The block SHALL implement a four-state FSM with states IDLE, WAIT, ISSUE and RESP.
REQ-019 The block SHALL drive req_ready=1 only in IDLE; a request is accepted when req_valid and req_ready are both 1 on a rising clock edge.
REQ-020 The block SHALL latch req_address on accept; later changes to req_address SHALL NOT affect the transaction in flight.
REQ-021 An address SHALL be in range when TEXT_BASE <= address <= TEXT_BASE + 4*TEXT_WORDS - 1, compared at ADDR_WIDTH bits with no wrap-around.
REQ-022 The word index SHALL be (address - TEXT_BASE) >> 2, truncated to $clog2(TEXT_WORDS) bits.
REQ-023 On an in-range accept, the FSM SHALL go to WAIT with a 4-bit counter loaded to WAIT_STATES; when WAIT_STATES=0 it SHALL go directly to ISSUE.
REQ-024 In WAIT, the counter SHALL decrement once per cycle and the FSM SHALL move to ISSUE on the cycle the counter reaches 1.
REQ-025 In ISSUE, the block SHALL assert mem_read=1 with mem_address set to the word index for exactly one cycle, then go to RESP.
REQ-026 On entry to RESP after ISSUE, the block SHALL register mem_q into rsp_data and set rsp_fault=0.
REQ-027 Latency from the accept edge to rsp_valid=1 SHALL be WAIT_STATES+2 cycles.
REQ-028 In RESP, the block SHALL hold rsp_valid=1 with rsp_data and rsp_fault stable until rsp_ready=1.
REQ-029 When rsp_valid and rsp_ready are both 1, the FSM SHALL return to IDLE on that edge; the next accept is possible one cycle later.
REQ-030 The block SHALL drive mem_read=0 in every state other than ISSUE.
REQ-031 rsp_ready SHALL be ignored outside RESP.

Reset
REQ-032 While reset=1, the block SHALL immediately set state=IDLE, counter=0, rsp_valid=0, rsp_fault=0, rsp_data=0, mem_read=0, mem_address=0 and req_ready=0.
REQ-033 After reset deasserts, req_ready SHALL be 1 from the first clock edge.
REQ-034 A reset in any state SHALL abort the transaction in flight, with no response and no further mem_read.

Configuration
REQ-035 The block SHALL support the macro TEXT_BUS_FAULT_EN.
REQ-036 With TEXT_BUS_FAULT_EN defined, an out-of-range or misaligned (address[1:0] != 0) accept SHALL go straight to RESP on the next edge with rsp_fault=1 and rsp_data=0, with no mem_read.
REQ-037 Without TEXT_BUS_FAULT_EN, rsp_fault SHALL be tied to 0 and address[1:0] SHALL be ignored.
REQ-038 Without TEXT_BUS_FAULT_EN, an out-of-range accept SHALL complete with the same timing as an in-range read but with no mem_read, returning rsp_data=0.

Verification
REQ-039 Scenario: WAIT_STATES=0, mem_q=32'hDEADBEEF, accept 0x00400000 -> one mem_read with mem_address=0; rsp_valid at the 2nd edge with rsp_data=DEADBEEF and rsp_fault=0.
REQ-040 Scenario: WAIT_STATES=3, accept 0x00400010 -> mem_read at accept+4 with mem_address=4; rsp_valid at accept+5.
REQ-041 Scenario: rsp_ready held 0 for 10 cycles -> rsp_valid, rsp_data and req_ready=0 stable throughout; IDLE one edge after rsp_ready=1.
REQ-042 Scenario: boundary addresses 0x00403FFC and 0x00404000 (TEXT_WORDS=4096) -> index 4095 read; then fault=1 (FAULT_EN) or data=0 with no mem_read (no FAULT_EN).
REQ-043 Scenario: FAULT_EN defined, accept 0x00400002 -> rsp_fault=1 one edge later, no mem_read.
REQ-044 Scenario: reset asserted mid-WAIT -> all outputs 0 immediately; after release, a new request completes normally.
